// File: rtl/snake_arbiter.sv
// Snake game arbiter: owns the food cell, detects eat / self-collision / win,
// keeps score and drives snake_body's grow request.
module snake_arbiter #(
  parameter int          COORD_W    = 3,
  parameter int          SCORE_W    = 8,
  parameter int          WIN_LENGTH = 15,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_enable,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic [COORD_W-1:0] body1_x,
  input  logic [COORD_W-1:0] body1_y,
  input  logic [COORD_W-1:0] body2_x,
  input  logic [COORD_W-1:0] body2_y,
  input  logic [3:0]         length,
  output logic               grow,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               eat_pulse,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               game_won
);

  typedef enum logic [1:0] {PLACE, ACTIVE, OVER} state_t;

  localparam logic [7:0] SEED    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [3:0] WIN_LEN = 4'(WIN_LENGTH);

  state_t             state;
  logic [7:0]         lfsr;
  logic               chk;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               cand_hit;
  logic               self_hit;
  logic               win_hit;
  logic               food_hit;

  always_comb begin
    cand_x   = lfsr[COORD_W-1:0];
    cand_y   = lfsr[2*COORD_W-1:COORD_W];
    cand_hit = (cand_x == head_x  && cand_y == head_y)  ||
               (cand_x == body1_x && cand_y == body1_y) ||
               (cand_x == body2_x && cand_y == body2_y);
    self_hit = (head_x == body1_x && head_y == body1_y) ||
               (head_x == body2_x && head_y == body2_y);
    win_hit  = (length >= WIN_LEN);
    food_hit = (head_x == food_x && head_y == food_y);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLACE;
      lfsr       <= SEED;
      chk        <= 1'b0;
      grow       <= 1'b0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      eat_pulse  <= 1'b0;
      score      <= '0;
      game_over  <= 1'b0;
      game_won   <= 1'b0;
    end else begin
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      chk       <= move_enable;
      eat_pulse <= 1'b0;
      if (state == OVER) begin
        grow <= 1'b0;
      end else begin
        // grow is consumed by the move that samples it; an eat only arms it when idle
        grow <= grow & ~move_enable;
        if (chk && self_hit) begin
          game_over <= 1'b1;
          grow      <= 1'b0;
          state     <= OVER;
        end else if (chk && win_hit) begin
          game_won <= 1'b1;
          grow     <= 1'b0;
          state    <= OVER;
        end else if (state == ACTIVE) begin
          if (chk && food_hit) begin
            eat_pulse  <= 1'b1;
            score      <= (score == '1) ? score : score + SCORE_W'(1);
            if (!grow) grow <= 1'b1;
            food_valid <= 1'b0;
            state      <= PLACE;
          end
        end else if (!cand_hit) begin
          food_x     <= cand_x;
          food_y     <= cand_y;
          food_valid <= 1'b1;
          state      <= ACTIVE;
        end
      end
    end
  end

endmodule
